// File: rtl/arm_dp_pkg.sv
// Shared types for the ARM data-processing issue stage.
//   dp_opcode_e : 4-bit data-processing opcodes (AND..MVN)
//   sh_type_e   : operand2 shift types
//   state_e     : issue FSM state encoding
//   dp_fields_t : instruction fields kept while the Rs read is pending
package arm_dp_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3,
    OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7,
    OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB,
    OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF
  } dp_opcode_e;

  typedef enum logic [1:0] {
    ShLsl = 2'b00,
    ShLsr = 2'b01,
    ShAsr = 2'b10,
    ShRor = 2'b11
  } sh_type_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRsRead = 2'd1,
    StIssue  = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] cond;
    dp_opcode_e opcode;
    logic       set_flags;
    logic [3:0] rd;
    logic [3:0] rs;
    sh_type_e   sh_type;
  } dp_fields_t;

  function automatic dp_fields_t decode_fields(input logic [31:0] instr);
    dp_fields_t f;
    f.cond      = instr[31:28];
    f.opcode    = dp_opcode_e'(instr[24:21]);
    f.set_flags = instr[20];
    f.rd        = instr[15:12];
    f.rs        = instr[11:8];
    f.sh_type   = sh_type_e'(instr[6:5]);
    return f;
  endfunction

endpackage

// File: rtl/operand2_shifter.sv
// Combinational ARM barrel shifter for operand2.
//   value_i    : value to shift (Rm, or zero-extended imm8)
//   sh_type_i  : LSL/LSR/ASR/ROR
//   amount_i   : shift amount (imm5 zero-extended, or Rs[7:0])
//   imm_form_i : 1 = immediate-shift encoding (#0 has special meanings)
//   carry_i    : current C flag
//   result_o   : shifted value
//   carry_o    : shifter carry-out
module operand2_shifter
  import arm_dp_pkg::*;
(
  input  logic [31:0] value_i,
  input  sh_type_e    sh_type_i,
  input  logic [7:0]  amount_i,
  input  logic        imm_form_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic        carry_o
);

  logic [4:0]  amt_lo;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] ror_res;
  logic [31:0] gen_res;
  logic        gen_c;
  logic        amt_big;

  // Shifts for amounts 1..31. The extra bit in each 33-bit word catches the
  // last bit shifted out, which is the carry.
  always_comb begin
    amt_lo  = amount_i[4:0];
    amt_big = |amount_i[7:5];
    lsl_w   = {1'b0, value_i} << amt_lo;
    lsr_w   = {value_i, 1'b0} >> amt_lo;
    asr_w   = $signed({value_i, 1'b0}) >>> amt_lo;
    ror_res = (value_i >> amt_lo) | (value_i << (6'd32 - {1'b0, amt_lo}));
    unique case (sh_type_i)
      ShLsl: begin gen_res = lsl_w[31:0];  gen_c = lsl_w[32];  end
      ShLsr: begin gen_res = lsr_w[32:1];  gen_c = lsr_w[0];   end
      ShAsr: begin gen_res = asr_w[32:1];  gen_c = asr_w[0];   end
      ShRor: begin gen_res = ror_res;      gen_c = ror_res[31]; end
    endcase
  end

  always_comb begin
    result_o = value_i;
    carry_o  = carry_i;
    if (imm_form_i) begin
      if (amt_lo == 5'd0) begin
        // #0 encodes LSL #0, LSR #32, ASR #32 and RRX respectively.
        unique case (sh_type_i)
          ShLsl: ;
          ShLsr: begin result_o = '0;                carry_o = value_i[31]; end
          ShAsr: begin result_o = {32{value_i[31]}}; carry_o = value_i[31]; end
          ShRor: begin result_o = {carry_i, value_i[31:1]}; carry_o = value_i[0]; end
        endcase
      end else begin
        result_o = gen_res;
        carry_o  = gen_c;
      end
    end else if (amount_i != 8'd0) begin
      unique case (sh_type_i)
        ShLsl: begin
          if (!amt_big && amt_lo != 5'd0) begin
            result_o = gen_res; carry_o = gen_c;
          end else begin
            result_o = '0;
            carry_o  = (amount_i == 8'd32) ? value_i[0] : 1'b0;
          end
        end
        ShLsr: begin
          if (!amt_big && amt_lo != 5'd0) begin
            result_o = gen_res; carry_o = gen_c;
          end else begin
            result_o = '0;
            carry_o  = (amount_i == 8'd32) ? value_i[31] : 1'b0;
          end
        end
        ShAsr: begin
          if (!amt_big && amt_lo != 5'd0) begin
            result_o = gen_res; carry_o = gen_c;
          end else begin
            result_o = {32{value_i[31]}};
            carry_o  = value_i[31];
          end
        end
        ShRor: begin
          // Multiples of 32 leave the value unchanged but still set carry.
          if (amt_lo == 5'd0) begin
            carry_o = value_i[31];
          end else begin
            result_o = gen_res; carry_o = gen_c;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/dp_issue_unit.sv
// Issue stage for ARM data-processing instructions.
//   clk, reset           : clock, synchronous active-high reset
//   instr_valid/instr/instr_ready : instruction handshake
//   carry_in             : current C flag (RRX and zero-amount shifts)
//   rf_addr_a/b, rf_data_a/b : combinational reg-file reads (A = Rn or Rs, B = Rm)
//   alu_valid/alu_ready  : ALU packet handshake
//   alu_cond/operation/data1/data2/rd/set_flags, shifter_carry : ALU packet
//   bad_instr            : one-cycle pulse when a non-DP instruction is dropped
module dp_issue_unit
  import arm_dp_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  output logic          instr_ready,
  input  logic          carry_in,
  output logic [RW-1:0] rf_addr_a,
  output logic [RW-1:0] rf_addr_b,
  input  logic [DW-1:0] rf_data_a,
  input  logic [DW-1:0] rf_data_b,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [3:0]    alu_cond,
  output logic [4:0]    alu_operation,
  output logic [DW-1:0] alu_data1,
  output logic [DW-1:0] alu_data2,
  output logic [RW-1:0] alu_rd,
  output logic          alu_set_flags,
  output logic          shifter_carry,
  output logic          bad_instr
);

  state_e     state_q, state_d;
  dp_fields_t fields_q;
  logic [DW-1:0] rn_q, rm_q;

  logic          valid_q, valid_d;
  logic          bad_q, bad_d;
  logic [3:0]    cond_q;
  logic [4:0]    op_q;
  logic [DW-1:0] data1_q, data2_q;
  logic [RW-1:0] rd_q;
  logic          sflags_q;
  logic          carry_q;

  dp_fields_t dec, pkt_fields;
  logic [DW-1:0] pkt_data1;
  logic       is_dp, is_regshift, slot_free, accept;
  logic       load_pkt, latch_ops;

  logic [31:0] sh_value, sh_result;
  sh_type_e    sh_type;
  logic [7:0]  sh_amount;
  logic        sh_imm_form, sh_carry;

  always_comb begin
    dec         = decode_fields(instr);
    is_dp       = (instr[27:26] == 2'b00);
    is_regshift = !instr[25] && instr[4];
    // The output slot is free when empty or being consumed this cycle.
    slot_free   = (state_q == StIdle) || (state_q == StIssue && alu_ready);
    instr_ready = slot_free && !reset;
    accept      = instr_valid && instr_ready;

    rf_addr_a = (state_q == StRsRead) ? RW'(fields_q.rs) : RW'(instr[19:16]);
    rf_addr_b = RW'(instr[3:0]);

    pkt_fields = (state_q == StRsRead) ? fields_q : dec;
    pkt_data1  = (state_q == StRsRead) ? rn_q : rf_data_a;
  end

  // Operand2 source: latched Rm with Rs amount, rotated imm8, or imm shift of Rm.
  always_comb begin
    if (state_q == StRsRead) begin
      sh_value    = rm_q;
      sh_type     = fields_q.sh_type;
      sh_amount   = rf_data_a[7:0];
      sh_imm_form = 1'b0;
    end else if (instr[25]) begin
      // Rotated immediate behaves like a register-form ROR by 2*rot.
      sh_value    = {24'h0, instr[7:0]};
      sh_type     = ShRor;
      sh_amount   = {3'b000, instr[11:8], 1'b0};
      sh_imm_form = 1'b0;
    end else begin
      sh_value    = rf_data_b;
      sh_type     = sh_type_e'(instr[6:5]);
      sh_amount   = {3'b000, instr[11:7]};
      sh_imm_form = 1'b1;
    end
  end

  operand2_shifter u_shifter (
    .value_i    (sh_value),
    .sh_type_i  (sh_type),
    .amount_i   (sh_amount),
    .imm_form_i (sh_imm_form),
    .carry_i    (carry_in),
    .result_o   (sh_result),
    .carry_o    (sh_carry)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    bad_d     = 1'b0;
    load_pkt  = 1'b0;
    latch_ops = 1'b0;
    unique case (state_q)
      StRsRead: begin
        load_pkt = 1'b1;
        valid_d  = 1'b1;
        state_d  = StIssue;
      end
      StIdle, StIssue: begin
        if (slot_free) begin
          valid_d = 1'b0;
          state_d = StIdle;
          if (accept) begin
            if (!is_dp) begin
              bad_d = 1'b1;
            end else if (is_regshift) begin
              latch_ops = 1'b1;
              state_d   = StRsRead;
            end else begin
              load_pkt = 1'b1;
              valid_d  = 1'b1;
              state_d  = StIssue;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      fields_q <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      cond_q   <= '0;
      op_q     <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      rd_q     <= '0;
      sflags_q <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      if (latch_ops) begin
        fields_q <= dec;
        rn_q     <= rf_data_a;
        rm_q     <= rf_data_b;
      end
      if (load_pkt) begin
        cond_q   <= pkt_fields.cond;
        op_q     <= {1'b0, pkt_fields.opcode};
        data1_q  <= pkt_data1;
        data2_q  <= sh_result;
        rd_q     <= RW'(pkt_fields.rd);
        sflags_q <= pkt_fields.set_flags;
        carry_q  <= sh_carry;
      end
    end
  end

  assign alu_valid     = valid_q;
  assign bad_instr     = bad_q;
  assign alu_cond      = cond_q;
  assign alu_operation = op_q;
  assign alu_data1     = data1_q;
  assign alu_data2     = data2_q;
  assign alu_rd        = rd_q;
  assign alu_set_flags = sflags_q;
  assign shifter_carry = carry_q;

endmodule

// File: tb/tb_dp_issue_unit.sv
module tb_dp_issue_unit;

  logic        clk = 1'b0;
  logic        reset, instr_valid, carry_in, alu_ready;
  logic [31:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        alu_valid, alu_set_flags, shifter_carry, bad_instr;
  logic [3:0]  alu_cond, alu_rd;
  logic [4:0]  alu_operation;
  logic [31:0] alu_data1, alu_data2;

  logic [31:0] rf [16];
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  always #5 clk = ~clk;

  dp_issue_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .carry_in      (carry_in),
    .rf_addr_a     (rf_addr_a),
    .rf_addr_b     (rf_addr_b),
    .rf_data_a     (rf_data_a),
    .rf_data_b     (rf_data_b),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_cond      (alu_cond),
    .alu_operation (alu_operation),
    .alu_data1     (alu_data1),
    .alu_data2     (alu_data2),
    .alu_rd        (alu_rd),
    .alu_set_flags (alu_set_flags),
    .shifter_carry (shifter_carry),
    .bad_instr     (bad_instr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand2 by the architectural definition: shift one bit at a time and
  // remember the last bit that fell out.
  function automatic logic [32:0] m_op2(input logic [31:0] ins, input logic [31:0] rm,
                                        input logic [31:0] rs, input logic cin);
    logic [31:0] v;
    logic        c;
    int          n;
    logic [1:0]  t;
    c = cin;
    if (ins[25]) begin
      v = {24'h0, ins[7:0]};
      n = 2 * int'(ins[11:8]);
      t = 2'b11;
    end else begin
      v = rm;
      t = ins[6:5];
      if (!ins[4]) begin
        n = int'(ins[11:7]);
        if (n == 0) begin
          if (t == 2'b00) return {cin, rm};
          if (t == 2'b11) return {rm[0], cin, rm[31:1]};
          n = 32;
        end
      end else begin
        n = int'(rs[7:0]);
        if (n == 0) return {cin, rm};
        if (t == 2'b11) begin
          if (n % 32 == 0) return {rm[31], rm};
          n = n % 32;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      case (t)
        2'b00:   begin c = v[31]; v = v << 1; end
        2'b01:   begin c = v[0];  v = v >> 1; end
        2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0];  v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  // Transaction-level expectations.
  bit          m_busy, m_valid, m_bad, m_zero;
  logic [31:0] m_pend, m_rn, m_rm;
  logic [3:0]  m_cond, m_rd;
  logic [4:0]  m_op;
  logic [31:0] m_d1, m_d2;
  logic        m_s, m_c;

  function automatic bit m_ready();
    return !reset && !m_busy && (!m_valid || alu_ready);
  endfunction

  task automatic m_load(input logic [31:0] ins, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] rs, input logic cin);
    m_cond      = ins[31:28];
    m_op        = {1'b0, ins[24:21]};
    m_d1        = rn;
    {m_c, m_d2} = m_op2(ins, rm, rs, cin);
    m_rd        = ins[15:12];
    m_s         = ins[20];
    m_valid     = 1'b1;
    m_zero      = 1'b0;
  endtask

  always @(posedge clk) begin
    bit rdy;
    rdy = m_ready();
    if (reset) begin
      m_busy = 0; m_valid = 0; m_bad = 0; m_zero = 1;
      m_cond = 0; m_op = 0; m_d1 = 0; m_d2 = 0; m_rd = 0; m_s = 0; m_c = 0;
    end else begin
      m_bad = 0;
      if (m_busy) begin
        m_load(m_pend, m_rn, m_rm, rf[m_pend[11:8]], carry_in);
        m_busy = 0;
      end else if (rdy) begin
        m_valid = 0;
        if (instr_valid) begin
          if (instr[27:26] != 2'b00) begin
            m_bad = 1;
          end else if (!instr[25] && instr[4]) begin
            m_busy = 1;
            m_pend = instr;
            m_rn   = rf[instr[19:16]];
            m_rm   = rf[instr[3:0]];
          end else begin
            m_load(instr, rf[instr[19:16]], rf[instr[3:0]], 32'h0, carry_in);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("instr_ready", instr_ready, m_ready());
    chk("alu_valid", alu_valid, m_valid);
    chk("bad_instr", bad_instr, m_bad);
    if (m_valid || m_zero) begin
      chk("alu_cond", alu_cond, m_cond);
      chk("alu_operation", alu_operation, m_op);
      chk("alu_data1", alu_data1, m_d1);
      chk("alu_data2", alu_data2, m_d2);
      chk("alu_rd", alu_rd, m_rd);
      chk("alu_set_flags", alu_set_flags, m_s);
      chk("shifter_carry", shifter_carry, m_c);
    end
  end

  // Returns one ns after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic cin);
    int n;
    bit ok;
    @(posedge clk); #1;
    instr = ins; instr_valid = 1'b1; carry_in = cin;
    n = 0; ok = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = instr_ready;
      n++;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    instr_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!alu_valid && lat < 8);
    if (!alu_valid) chk("valid_timeout", alu_valid, 1);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        cin;
    logic [31:0] d2;
    logic        c;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int lat;
    for (int i = 0; i < 16; i++) rf[i] = 32'h1111_1111 * i;
    rf[0] = 32'h1234_5678; rf[1] = 32'd5; rf[2] = 32'hF000_0010; rf[3] = 32'h8000_0000;
    rf[4] = 32'd32; rf[5] = 32'd2; rf[6] = 32'd0; rf[7] = 32'd1;
    rf[9] = 32'h24; rf[10] = 32'hF; rf[12] = 32'h20; rf[13] = 32'h8000_0001;
    rf[14] = 32'd33; rf[15] = 32'hC8;

    vecs[0] = '{32'hE0A18242, 1'b0, 32'hFF00_0001, 1'b0, 1}; // ADC ASR #4
    vecs[1] = '{32'hE0C1B97A, 1'b0, 32'hF000_0000, 1'b1, 2}; // SBC ROR by 36
    vecs[2] = '{32'hE0E10C7D, 1'b0, 32'h8000_0001, 1'b1, 2}; // RSC ROR by 32
    vecs[3] = '{32'hE1913E33, 1'b1, 32'h0000_0000, 1'b0, 2}; // ORRS LSR by 33
    vecs[4] = '{32'hE0204F53, 1'b0, 32'hFFFF_FFFF, 1'b1, 2}; // EOR ASR by 200
    vecs[5] = '{32'hE3A0107F, 1'b1, 32'h0000_007F, 1'b1, 1}; // MOV #0x7F rot 0
    vecs[6] = '{32'hE1510F87, 1'b1, 32'h8000_0000, 1'b0, 1}; // CMP LSL #31
    vecs[7] = '{32'hE1E02612, 1'b1, 32'hF000_0010, 1'b1, 2}; // MVN LSL by 0

    reset = 1'b1; instr_valid = 1'b0; instr = 32'h0; carry_in = 1'b0; alu_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_data2", alu_data2, 0);
    reset = 1'b0;

    // T1 ADD rotated immediate
    send(32'hE2812CFF, 1'b0);
    wait_valid(lat);
    chk("t1_latency", lat, 1);
    chk("t1_operation", alu_operation, 5'b00100);
    chk("t1_data1", alu_data1, 32'd5);
    chk("t1_data2", alu_data2, 32'h0000_FF00);
    chk("t1_rd", alu_rd, 4'd2);
    chk("t1_cond", alu_cond, 4'hE);

    // T2 MOV LSR #0
    send(32'hE1A00023, 1'b0);
    wait_valid(lat);
    chk("t2_data2", alu_data2, 32'h0);
    chk("t2_carry", shifter_carry, 1'b1);

    // T3 MOV RRX
    send(32'hE1A00065, 1'b1);
    wait_valid(lat);
    chk("t3_data2", alu_data2, 32'h8000_0001);
    chk("t3_carry", shifter_carry, 1'b0);

    // T4 SUB LSL by Rs
    send(32'hE0406417, 1'b0);
    wait_valid(lat);
    chk("t4a_latency", lat, 2);
    chk("t4a_data2", alu_data2, 32'h0);
    chk("t4a_carry", shifter_carry, 1'b1);
    repeat (2) @(posedge clk);
    rf[4] = 32'd40;
    send(32'hE0406417, 1'b0);
    wait_valid(lat);
    chk("t4b_data2", alu_data2, 32'h0);
    chk("t4b_carry", shifter_carry, 1'b0);

    foreach (vecs[i]) begin
      send(vecs[i].ins, vecs[i].cin);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_data2", i), alu_data2, vecs[i].d2);
      chk($sformatf("vec%0d_carry", i), shifter_carry, vecs[i].c);
    end
    carry_in = 1'b0;

    // T5 backpressure then back-to-back
    @(posedge clk); #1;
    alu_ready = 1'b0;
    send(32'hE2812CFF, 1'b0);
    wait_valid(lat);
    @(posedge clk); #1;
    instr = 32'hE3A0107F; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_ready", instr_ready, 0);
      chk("t5_hold_valid", alu_valid, 1);
      chk("t5_hold_data2", alu_data2, 32'h0000_FF00);
      @(posedge clk); #1;
    end
    alu_ready = 1'b1;
    @(negedge clk);
    chk("t5_release_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr = 32'hE1A00023;
    @(negedge clk);
    chk("t5_b2b_valid1", alu_valid, 1);
    chk("t5_b2b_data2_1", alu_data2, 32'h0000_007F);
    chk("t5_b2b_ready", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t5_b2b_valid2", alu_valid, 1);
    chk("t5_b2b_carry2", shifter_carry, 1'b1);
    @(negedge clk);
    chk("t5_drain_valid", alu_valid, 0);

    // T6 reset while in RS_READ
    send(32'hE0406417, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", alu_valid, 0);
    chk("t6_rst_ready", instr_ready, 1);
    repeat (3) @(negedge clk);
    chk("t6_no_late_valid", alu_valid, 0);

    // T6 non-DP instruction
    send(32'hE5901000, 1'b0);
    @(negedge clk);
    chk("t6_bad_pulse", bad_instr, 1);
    chk("t6_bad_no_valid", alu_valid, 0);
    @(negedge clk);
    chk("t6_bad_clear", bad_instr, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
